// File: rtl/nx_fifo_ram_1r1w_fwft.sv
// Show-ahead FIFO over a 1R1W array with a registered read, even-parity check
// on every word, parity error injection, and registered occupancy flags.
module nx_fifo_ram_1r1w_fwft #(
  parameter int DATA_W    = 71,
  parameter int DEPTH     = 2048,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic              clear,
  input  logic              inject_err,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  used_slots,
  output logic [CNT_W-1:0]  free_slots,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  function automatic logic par_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Array slots are released only on pop, so the prefetch copies never need
  // a slot of their own and capacity stays exactly DEPTH.
  logic [DATA_W:0]    mem [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]   used_q, used_d, unread_q, unread_d;
  logic               vld_p0_q, vld_p1_q;
  logic [DATA_W:0]    dat_p0_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rerr_q, full_q, afull_q, aempty_q, ovf_q, udf_q;
  logic [CNT_W-1:0]   free_q;
  logic               push, pop, adv, issue;

  always_comb begin
    push  = wen && !full_q && !clear;
    pop   = ren && vld_p1_q && !clear;
    adv   = vld_p0_q && (!vld_p1_q || pop);
    issue = (unread_q != '0) && (!vld_p0_q || adv) && !clear;
    used_d = used_q;
    if (push && !pop)      used_d = used_q + ONE_C;
    else if (!push && pop) used_d = used_q - ONE_C;
    unread_d = unread_q;
    if (push && !issue)      unread_d = unread_q + ONE_C;
    else if (!push && issue) unread_d = unread_q - ONE_C;
  end

  // Stage p0: array write and registered array read
  always_ff @(posedge clk) begin
    if (push)  mem[wptr_q] <= {par_f(wdata) ^ inject_err, wdata};
    if (issue) dat_p0_q <= mem[rptr_q];
  end

  // Stage p1: head register, parity check and occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0; rptr_q <= '0; used_q <= '0; unread_q <= '0;
      vld_p0_q <= 1'b0; vld_p1_q <= 1'b0; rdata_q <= '0; rerr_q <= 1'b0;
      full_q <= 1'b0; afull_q <= 1'b0; aempty_q <= 1'b1; free_q <= DEPTH_C;
      ovf_q <= 1'b0; udf_q <= 1'b0;
    end else if (clear) begin
      wptr_q <= '0; rptr_q <= '0; used_q <= '0; unread_q <= '0;
      vld_p0_q <= 1'b0; vld_p1_q <= 1'b0; rdata_q <= '0; rerr_q <= 1'b0;
      full_q <= 1'b0; afull_q <= 1'b0; aempty_q <= 1'b1; free_q <= DEPTH_C;
      ovf_q <= 1'b0; udf_q <= 1'b0;
    end else begin
      if (push)  wptr_q <= wptr_q + AW'(1);
      if (issue) rptr_q <= rptr_q + AW'(1);
      used_q   <= used_d;
      unread_q <= unread_d;
      vld_p0_q <= issue || (vld_p0_q && !adv);
      if (adv) begin
        vld_p1_q <= 1'b1;
        rdata_q  <= dat_p0_q[DATA_W-1:0];
        rerr_q   <= ^dat_p0_q;
      end else if (pop) begin
        vld_p1_q <= 1'b0;
        rerr_q   <= 1'b0;
      end
      full_q   <= (used_d == DEPTH_C);
      afull_q  <= (used_d >= AFULL_C);
      aempty_q <= (used_d <= AEMPTY_C);
      free_q   <= DEPTH_C - used_d;
      ovf_q    <= wen && full_q;
      udf_q    <= ren && !vld_p1_q;
    end
  end

  assign rdata        = rdata_q;
  assign rerr         = rerr_q;
  assign empty        = !vld_p1_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign used_slots   = used_q;
  assign free_slots   = free_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
